neuron_layer_driver: RTL and testbench
======================================

Name: neuron_layer_driver

Overview:
- Initiator for one `neuron` instance. It evaluates a whole layer by time-multiplexing that single neuron.
- For each output neuron j it:
  - fetches weight row j from the weight memory,
  - sends input_number, inputs and weights to the neuron on three independent valid/ready channels,
  - collects neuron_sum and overflow into a result vector.
- It is the upstream counterpart of `neuron`. It sits between the layer controller and the neuron.

Parameters:
- NEURON_NUM, 5, max inputs per neuron (vector lanes)
- NEURON_OUTPUT_WIDTH, 10, width of each neuron_sum
- ACTIVATION_WIDTH, 9, width of each activation lane
- WEIGHT_CELL_WIDTH, 16, width of each weight lane
- LAYER_MAX, 5, max output neurons per layer
- ADDR_WIDTH, 8, weight memory address width

Ports:
(CW = log2(NEURON_NUM)+1, OW = log2(LAYER_MAX)+1)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_valid  in  1  layer job offered
- start_ready  out  1  high only in IDLE
- in_count  in  CW  inputs per neuron
- out_count  in  OW  output neurons in layer
- activations  in  NEURON_NUM*ACTIVATION_WIDTH  layer input vector
- weight_base  in  ADDR_WIDTH  address of weight row 0
- weight_rd  out  1  memory read strobe
- weight_addr  out  ADDR_WIDTH  row address
- weight_data  in  NEURON_NUM*WEIGHT_CELL_WIDTH  row data, valid the cycle after weight_rd
- input_number  out  CW  to neuron
- input_number_valid  out  1  to neuron
- input_number_ready  in  1  from neuron
- inputs  out  NEURON_NUM*ACTIVATION_WIDTH  to neuron
- inputs_valid  out  1  to neuron
- inputs_ready  in  1  from neuron
- weights  out  NEURON_NUM*WEIGHT_CELL_WIDTH  to neuron
- weights_valid  out  1  to neuron
- weights_ready  in  1  from neuron
- neuron_sum  in  NEURON_OUTPUT_WIDTH  from neuron
- overflow  in  1  from neuron
- neuron_sum_valid  in  1  from neuron
- neuron_sum_ready  out  1  to neuron
- result  out  LAYER_MAX*NEURON_OUTPUT_WIDTH  lane j = neuron j
- result_overflow  out  LAYER_MAX  bit j = overflow of neuron j
- result_valid  out  1  high in DONE
- result_ready  in  1  consumer accept

Behaviour:

Reset:
- All valids, weight_rd, neuron_sum_ready and result_valid are 0. result, result_overflow, row index j and all latches are 0. State is IDLE.
- rst mid-job aborts on the next edge. There is no drain; the neuron must be reset alongside.

States:
- IDLE
  - start_ready=1.
  - On start_valid, latch in_count, activations and weight_base.
  - Latch out_count clamped to LAYER_MAX.
  - Clear result, result_overflow and j.
  - If in_count==0, in_count>NEURON_NUM, or out_count==0: go to DONE with all-zero results, and never touch the neuron. Otherwise go to FETCH.
- FETCH
  - One cycle: weight_rd=1, weight_addr=weight_base+j (wraps modulo 2^ADDR_WIDTH). Go to WAIT.
- WAIT
  - One cycle: capture weight_data into the weights register.
  - Set all three out-valids to 1 on the next edge. Go to ISSUE.
- ISSUE
  - Each valid drops independently the cycle after its own valid&ready handshake.
  - Payloads are held stable while their valid is high.
  - When all three have completed, go to COLLECT. This includes the case where all three complete in the same cycle, which gives a 1-cycle ISSUE.
- COLLECT
  - neuron_sum_ready=1.
  - On neuron_sum_valid, write result lane j = neuron_sum and result_overflow[j] = overflow.
  - If j==out_count-1, go to DONE; else j<=j+1 and go to FETCH.
- DONE
  - result_valid=1; result is stable.
  - On result_ready, go to IDLE. The result registers keep their values until the next start is accepted.

Handshake and timing rules:
- No out-valid is asserted outside ISSUE.
- neuron_sum_ready is 0 outside COLLECT.
- start_valid in a non-IDLE state is ignored (start_ready=0).
- Per-neuron overhead beyond the neuron itself: FETCH 1 + WAIT 1 + ISSUE ≥1 + COLLECT ≥1 cycle.
- Result lanes ≥ out_count stay 0.

Optional Feature:
Macro: NEURON_LAYER_DRIVER_OVF_COUNT_EN
- Defined:
  - Adds output overflow_count (OW bits). It counts result_overflow bits set during the current job.
  - Cleared on start acceptance; increments in COLLECT on each handshake with overflow=1.
  - Valid while result_valid; saturates at LAYER_MAX.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Test Plan:
- Basic job: in_count=3, out_count=2, activations lanes {1,2,3}, rows {1,1,1} and {2,0,-1}, real neuron, FRACTION=0 -> result lanes {6,-1}, result_overflow=0, exactly 2 weight_rd pulses at base and base+1.
- Independent channel stalls: hold weights_ready low 4 cycles after inputs/input_number handshake -> weights payload stable, no extra handshakes, same result.
- Output backpressure: neuron_sum_valid asserted but driver in ISSUE -> no capture. Hold result_ready low 10 cycles in DONE -> result stable, start_ready=0, a new start_valid is ignored.
- Degenerate jobs: out_count=0 or in_count=0 -> DONE after 1 cycle, results 0, no neuron valids. out_count=7 with LAYER_MAX=5 -> exactly 5 neurons evaluated.
- Overflow: row of large weights driving neuron overflow on neuron 1 of 3 -> result_overflow=3'b010; with NEURON_LAYER_DRIVER_OVF_COUNT_EN, overflow_count=1.
- Reset during ISSUE with inputs_valid=1 -> next cycle all valids 0, state IDLE, start_ready=1; a follow-up job completes correctly. Address wrap: weight_base=255, out_count=2 -> addresses 255, 0.

Source files
------------

// File: rtl/neuron_layer_driver.sv
// neuron_layer_driver: evaluates a whole layer by time-multiplexing a single neuron
// Fetches weight row j, issues input_number/inputs/weights on three independent
// valid/ready channels, collects neuron_sum/overflow into result lane j.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start_*, in_count, out_count,
//   activations, weight_base      layer job request (accepted only in IDLE)
//   weight_rd/addr/data           weight memory, data valid the cycle after weight_rd
//   input_number*, inputs*,
//   weights*                      three independent channels to the neuron
//   neuron_sum*, overflow         neuron response
//   result*, result_overflow      layer result, valid while in DONE
//   overflow_count                only with NEURON_LAYER_DRIVER_OVF_COUNT_EN defined
module neuron_layer_driver #(
  parameter int NEURON_NUM = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH = 9,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int LAYER_MAX = 5,
  parameter int ADDR_WIDTH = 8,
  localparam int CW = $clog2(NEURON_NUM) + 1,
  localparam int OW = $clog2(LAYER_MAX) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_valid,
  output logic                                    start_ready,
  input  logic [CW-1:0]                           in_count,
  input  logic [OW-1:0]                           out_count,
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  activations,
  input  logic [ADDR_WIDTH-1:0]                   weight_base,
  output logic                                    weight_rd,
  output logic [ADDR_WIDTH-1:0]                   weight_addr,
  input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weight_data,
  output logic [CW-1:0]                           input_number,
  output logic                                    input_number_valid,
  input  logic                                    input_number_ready,
  output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  inputs,
  output logic                                    inputs_valid,
  input  logic                                    inputs_ready,
  output logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights,
  output logic                                    weights_valid,
  input  logic                                    weights_ready,
  input  logic [NEURON_OUTPUT_WIDTH-1:0]          neuron_sum,
  input  logic                                    overflow,
  input  logic                                    neuron_sum_valid,
  output logic                                    neuron_sum_ready,
  output logic [LAYER_MAX*NEURON_OUTPUT_WIDTH-1:0] result,
  output logic [LAYER_MAX-1:0]                    result_overflow,
`ifdef NEURON_LAYER_DRIVER_OVF_COUNT_EN
  output logic [OW-1:0]                           overflow_count,
`endif
  output logic                                    result_valid,
  input  logic                                    result_ready
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_COLLECT, S_DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] outc_q, outc_d, j_q, j_d;
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] act_q, act_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w_q, w_d;
  // {weights, inputs, input_number} valids
  logic [2:0] v_q, v_d;
  logic [LAYER_MAX-1:0][NEURON_OUTPUT_WIDTH-1:0] res_q, res_d;
  logic [LAYER_MAX-1:0] rovf_q, rovf_d;
  logic start_hs, sum_hs;
  assign start_ready = state_q == S_IDLE;
  assign weight_rd = state_q == S_FETCH;
  assign neuron_sum_ready = state_q == S_COLLECT;
  assign result_valid = state_q == S_DONE;
  assign start_hs = start_ready & start_valid;
  assign sum_hs = neuron_sum_ready & neuron_sum_valid;
  assign weight_addr = base_q + ADDR_WIDTH'(j_q);
  assign input_number = cnt_q;
  assign inputs = act_q;
  assign weights = w_q;
  assign {weights_valid, inputs_valid, input_number_valid} = v_q;
  assign result = res_q;
  assign result_overflow = rovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    outc_d = outc_q;
    j_d = j_q;
    act_d = act_q;
    base_d = base_q;
    w_d = w_q;
    v_d = v_q;
    res_d = res_q;
    rovf_d = rovf_q;
    case (state_q)
      S_IDLE: if (start_valid) begin
        cnt_d = in_count;
        act_d = activations;
        base_d = weight_base;
        outc_d = out_count > OW'(LAYER_MAX) ? OW'(LAYER_MAX) : out_count;
        res_d = '0;
        rovf_d = '0;
        j_d = '0;
        // Degenerate jobs complete without ever touching the neuron
        state_d = (~|in_count || in_count > CW'(NEURON_NUM) || ~|out_count) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        w_d = weight_data;
        v_d = '1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Each channel retires on its own handshake; leave once all three are done
        v_d = v_q & ~{weights_ready, inputs_ready, input_number_ready};
        state_d = ~|v_d ? S_COLLECT : S_ISSUE;
      end
      S_COLLECT: if (neuron_sum_valid) begin
        for (int k = 0; k < LAYER_MAX; k++) begin
          if (j_q == OW'(k)) begin
            res_d[k] = neuron_sum;
            rovf_d[k] = overflow;
          end
        end
        j_d = j_q + 1'b1;
        state_d = j_q == outc_q - 1'b1 ? S_DONE : S_FETCH;
      end
      S_DONE: state_d = result_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      outc_q <= '0;
      j_q <= '0;
      act_q <= '0;
      base_q <= '0;
      w_q <= '0;
      v_q <= '0;
      res_q <= '0;
      rovf_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      outc_q <= outc_d;
      j_q <= j_d;
      act_q <= act_d;
      base_q <= base_d;
      w_q <= w_d;
      v_q <= v_d;
      res_q <= res_d;
      rovf_q <= rovf_d;
    end
  end
`ifdef NEURON_LAYER_DRIVER_OVF_COUNT_EN
  logic [OW-1:0] ovc_q, ovc_d;
  assign ovc_d = start_hs ? '0 : (sum_hs && overflow && ovc_q < OW'(LAYER_MAX)) ? ovc_q + 1'b1 : ovc_q;
  always_ff @(posedge clk) begin
    if (rst) ovc_q <= '0;
    else ovc_q <= ovc_d;
  end
  assign overflow_count = ovc_q;
`endif
endmodule

// File: tb/tb_neuron_layer_driver.sv
// tb_neuron_layer_driver: randomized self-checking bench with a behavioural neuron and weight memory
module tb_neuron_layer_driver;
  localparam int NN = 5, AW = 9, WW = 16, NOW = 10, LM = 5, ADW = 8, CW = 4, OW = 4;
  typedef struct {
    logic [LM*NOW-1:0] r;
    logic [LM-1:0] ro;
    int nrd;
    bit addr_ok;
    int hs[4];
    int perr;
    int lat;
    bit ret_ok;
    logic [OW-1:0] ovc;
  } obs_t;
  logic clk = 0, rst = 1;
  logic start_valid = 0, start_ready;
  logic [CW-1:0] in_count = 0;
  logic [OW-1:0] out_count = 0;
  logic [NN*AW-1:0] activations = 0;
  logic [ADW-1:0] weight_base = 0;
  logic weight_rd;
  logic [ADW-1:0] weight_addr;
  logic [NN*WW-1:0] weight_data = 0;
  logic [CW-1:0] input_number;
  logic input_number_valid, input_number_ready = 0;
  logic [NN*AW-1:0] inputs;
  logic inputs_valid, inputs_ready = 0;
  logic [NN*WW-1:0] weights;
  logic weights_valid, weights_ready = 0;
  logic [NOW-1:0] neuron_sum;
  logic overflow, neuron_sum_valid, neuron_sum_ready;
  logic [LM*NOW-1:0] result;
  logic [LM-1:0] result_overflow;
  logic [OW-1:0] overflow_count;
  logic result_valid, result_ready = 0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  neuron_layer_driver dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .in_count(in_count), .out_count(out_count), .activations(activations), .weight_base(weight_base),
    .weight_rd(weight_rd), .weight_addr(weight_addr), .weight_data(weight_data),
    .input_number(input_number), .input_number_valid(input_number_valid), .input_number_ready(input_number_ready),
    .inputs(inputs), .inputs_valid(inputs_valid), .inputs_ready(inputs_ready),
    .weights(weights), .weights_valid(weights_valid), .weights_ready(weights_ready),
    .neuron_sum(neuron_sum), .overflow(overflow), .neuron_sum_valid(neuron_sum_valid), .neuron_sum_ready(neuron_sum_ready),
    .result(result), .result_overflow(result_overflow),
`ifdef NEURON_LAYER_DRIVER_OVF_COUNT_EN
    .overflow_count(overflow_count),
`endif
    .result_valid(result_valid), .result_ready(result_ready)
  );
`ifndef NEURON_LAYER_DRIVER_OVF_COUNT_EN
  assign overflow_count = '0;
`endif
  // Dot product of the first n lanes, signed, truncated to NOW bits; overflow if out of signed range
  function automatic void nfn(input int n, input logic [NN*AW-1:0] a, input logic [NN*WW-1:0] w,
                              output logic [NOW-1:0] s, output logic o);
    longint acc = 0;
    for (int k = 0; k < n; k++) acc += longint'($signed(a[k*AW+:AW])) * longint'($signed(w[k*WW+:WW]));
    s = acc[NOW-1:0];
    o = acc > 511 || acc < -512;
  endfunction
  // Weight memory: data appears the cycle after weight_rd, garbage otherwise
  logic [NN*WW-1:0] mem [256];
  logic [ADW-1:0] rd_log [0:4095];
  int rd_cnt = 0;
  always @(posedge clk) begin
    weight_data <= weight_rd ? mem[weight_addr] : (NN*WW)'({$urandom, $urandom, $urandom});
    if (weight_rd) begin
      rd_log[rd_cnt] <= weight_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end
  // Behavioural neuron: 0 random readies, 1 always ready, 2 weights stalled 4 cycles, 3 never ready
  int rdy_mode = 1;
  bit early = 0;
  logic got_n = 0, got_i = 0, got_w = 0;
  logic [CW-1:0] n_lat = 0;
  logic [NN*AW-1:0] i_lat = 0;
  logic [NN*WW-1:0] w_lat = 0;
  logic [NOW-1:0] m_sum;
  logic m_ovf;
  int dly = 0, wcnt = 0, hs_n = 0, hs_i = 0, hs_w = 0, hs_s = 0;
  int dup_err = 0, early_cap = 0, stab_err = 0, excl_err = 0;
  wire all_got = got_n & got_i & got_w;
  always_comb nfn(int'(n_lat), i_lat, w_lat, m_sum, m_ovf);
  assign neuron_sum_valid = all_got ? dly == 0 : early;
  assign neuron_sum = all_got ? m_sum : 10'h155;
  assign overflow = all_got ? m_ovf : 1'b1;
  always @(posedge clk) begin
    if (rst) begin
      got_n <= 0; got_i <= 0; got_w <= 0; dly <= 0; wcnt <= 0;
    end else begin
      if (input_number_valid && input_number_ready) begin
        if (got_n) dup_err <= dup_err + 1;
        got_n <= 1; n_lat <= input_number; hs_n <= hs_n + 1;
      end
      if (inputs_valid && inputs_ready) begin
        if (got_i) dup_err <= dup_err + 1;
        got_i <= 1; i_lat <= inputs; hs_i <= hs_i + 1;
      end
      if (weights_valid && weights_ready) begin
        if (got_w) dup_err <= dup_err + 1;
        got_w <= 1; w_lat <= weights; hs_w <= hs_w + 1;
      end
      if (got_n && got_i && !got_w) wcnt <= wcnt + 1;
      if (neuron_sum_valid && neuron_sum_ready) begin
        if (!all_got) early_cap <= early_cap + 1;
        got_n <= 0; got_i <= 0; got_w <= 0; wcnt <= 0;
        dly <= $urandom_range(0, 3); hs_s <= hs_s + 1;
      end else if (all_got && dly > 0) dly <= dly - 1;
    end
    input_number_ready <= rdy_mode == 0 ? $urandom_range(0, 1) == 1 : rdy_mode != 3;
    inputs_ready <= rdy_mode == 0 ? $urandom_range(0, 1) == 1 : rdy_mode != 3;
    weights_ready <= rdy_mode == 0 ? $urandom_range(0, 1) == 1 : rdy_mode == 1 ? 1'b1 :
                     rdy_mode == 2 ? (got_n && got_i && wcnt >= 4) : 1'b0;
  end
  // Protocol monitor: payload/valid held until handshake; channels exclusive with other phases
  logic p_n = 0, p_i = 0, p_w = 0;
  logic [CW-1:0] l_n;
  logic [NN*AW-1:0] l_i;
  logic [NN*WW-1:0] l_w;
  always @(posedge clk) begin
    if (rst) begin
      p_n <= 0; p_i <= 0; p_w <= 0;
    end else begin
      if ((p_n && (!input_number_valid || input_number !== l_n)) || (p_i && (!inputs_valid || inputs !== l_i)) ||
          (p_w && (!weights_valid || weights !== l_w))) stab_err <= stab_err + 1;
      if ((input_number_valid | inputs_valid | weights_valid) && (neuron_sum_ready | result_valid | start_ready | weight_rd))
        excl_err <= excl_err + 1;
      p_n <= input_number_valid && !input_number_ready; l_n <= input_number;
      p_i <= inputs_valid && !inputs_ready; l_i <= inputs;
      p_w <= weights_valid && !weights_ready; l_w <= weights;
    end
  end
  function automatic void ref_job(input int ic, input int oc, input logic [ADW-1:0] base, input logic [NN*AW-1:0] acts,
                                  output logic [LM*NOW-1:0] r, output logic [LM-1:0] ro, output int n);
    logic [NOW-1:0] s;
    logic o;
    r = '0;
    ro = '0;
    n = (ic < 1 || ic > NN || oc < 1) ? 0 : (oc > LM ? LM : oc);
    for (int j = 0; j < n; j++) begin
      nfn(ic, acts, mem[8'(int'(base) + j)], s, o);
      r[j*NOW+:NOW] = s;
      ro[j] = o;
    end
  endfunction
  function automatic logic [NN*AW-1:0] rand_acts();
    logic [NN*AW-1:0] a;
    for (int k = 0; k < NN; k++) a[k*AW+:AW] = 9'($urandom_range(0, 63)) - 9'd32;
    return a;
  endfunction
  task automatic run_job(input int ic, input int oc, input logic [ADW-1:0] base, input logic [NN*AW-1:0] acts,
                         input int hold, output obs_t o);
    int rd0, e0;
    int h0[4];
    logic [LM*NOW-1:0] r0;
    @(negedge clk);
    rd0 = rd_cnt;
    h0 = '{hs_n, hs_i, hs_w, hs_s};
    e0 = dup_err + early_cap + stab_err + excl_err;
    start_valid = 1; in_count = CW'(ic); out_count = OW'(oc); activations = acts; weight_base = base;
    @(negedge clk);
    start_valid = 0; in_count = CW'($urandom); out_count = OW'($urandom);
    activations = (NN*AW)'({$urandom, $urandom}); weight_base = ADW'($urandom);
    o.lat = 0;
    while (!result_valid && o.lat < 3000) begin
      @(negedge clk);
      o.lat++;
    end
    o.r = result;
    o.ro = result_overflow;
    o.ovc = overflow_count;
    r0 = result;
    o.ret_ok = 1;
    for (int k = 0; k < hold; k++) begin
      start_valid = 1;
      @(negedge clk);
      if (result !== r0 || start_ready || !result_valid) o.ret_ok = 0;
    end
    start_valid = 0;
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    if (!start_ready || result !== r0) o.ret_ok = 0;
    o.nrd = rd_cnt - rd0;
    o.addr_ok = 1;
    for (int k = 0; k < o.nrd; k++) if (rd_log[rd0 + k] !== 8'(int'(base) + k)) o.addr_ok = 0;
    o.hs = '{hs_n - h0[0], hs_i - h0[1], hs_w - h0[2], hs_s - h0[3]};
    o.perr = dup_err + early_cap + stab_err + excl_err - e0 + (o.lat >= 3000 ? 1 : 0);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({start_ready, result_valid, weight_rd, input_number_valid, inputs_valid, weights_valid, neuron_sum_ready} !== 7'b1000000)
      $display("FAIL reset_ctrl: got %b expected 1000000", {start_ready, result_valid, weight_rd, input_number_valid,
               inputs_valid, weights_valid, neuron_sum_ready});
    else passed++;
    total++;
    if ({result, result_overflow} !== '0) $display("FAIL reset_result: got %h expected 0", {result, result_overflow});
    else passed++;
    rst = 0;
  endtask
  task automatic basic_rows();
    mem[20] = {16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
    mem[21] = {16'd0, 16'd0, 16'hffff, 16'd0, 16'd2};
  endtask
  task automatic test_basic();
    obs_t o;
    basic_rows();
    rdy_mode = 1;
    run_job(3, 2, 8'd20, {9'd0, 9'd0, 9'd3, 9'd2, 9'd1}, 0, o);
    total++;
    if (o.r !== {30'd0, 10'h3ff, 10'd6}) $display("FAIL basic_result: got %h expected %h", o.r, {30'd0, 10'h3ff, 10'd6});
    else passed++;
    total++;
    if (o.ro !== '0) $display("FAIL basic_ovf: got %b expected 00000", o.ro);
    else passed++;
    total++;
    if (o.nrd !== 2 || !o.addr_ok) $display("FAIL basic_reads: got %0d reads addr_ok=%0d expected 2 reads at 20,21", o.nrd, o.addr_ok);
    else passed++;
    total++;
    if (o.hs[0] != 2 || o.hs[1] != 2 || o.hs[2] != 2 || o.hs[3] != 2 || o.perr != 0)
      $display("FAIL basic_handshakes: got %0d/%0d/%0d/%0d perr=%0d expected 2/2/2/2 perr=0", o.hs[0], o.hs[1], o.hs[2], o.hs[3], o.perr);
    else passed++;
  endtask
  task automatic test_stall();
    obs_t o;
    basic_rows();
    rdy_mode = 2;
    run_job(3, 2, 8'd20, {9'd0, 9'd0, 9'd3, 9'd2, 9'd1}, 0, o);
    total++;
    if (o.r !== {30'd0, 10'h3ff, 10'd6}) $display("FAIL stall_result: got %h expected %h", o.r, {30'd0, 10'h3ff, 10'd6});
    else passed++;
    total++;
    if (o.hs[2] != 2 || o.hs[0] != 2 || o.perr != 0)
      $display("FAIL stall_protocol: got weights hs %0d number hs %0d perr=%0d expected 2 2 0", o.hs[2], o.hs[0], o.perr);
    else passed++;
  endtask
  task automatic test_backpressure();
    obs_t o;
    logic [LM*NOW-1:0] er;
    logic [LM-1:0] ero;
    logic [NN*AW-1:0] a;
    int n;
    rdy_mode = 0;
    early = 1;
    a = rand_acts();
    ref_job(4, 3, 8'd90, a, er, ero, n);
    run_job(4, 3, 8'd90, a, 10, o);
    early = 0;
    total++;
    if (o.r !== er || o.ro !== ero) $display("FAIL bp_result: got %h/%b expected %h/%b", o.r, o.ro, er, ero);
    else passed++;
    total++;
    if (!o.ret_ok) $display("FAIL bp_done_hold: got unstable result or start_ready in DONE expected stable");
    else passed++;
    total++;
    if (o.perr != 0) $display("FAIL bp_protocol: got %0d violations (early capture/stability) expected 0", o.perr);
    else passed++;
  endtask
  task automatic test_degenerate();
    obs_t o;
    logic [LM*NOW-1:0] er;
    logic [LM-1:0] ero;
    logic [NN*AW-1:0] a;
    int n;
    int cases[3][2] = '{'{3, 0}, '{0, 3}, '{6, 2}};
    rdy_mode = 1;
    foreach (cases[c]) begin
      run_job(cases[c][0], cases[c][1], 8'd7, rand_acts(), 0, o);
      total++;
      if (o.lat != 0 || o.r !== '0 || o.ro !== '0 || o.nrd != 0 || o.hs[0] + o.hs[1] + o.hs[2] != 0 || o.perr != 0)
        $display("FAIL degenerate_%0d_%0d: got lat=%0d r=%h reads=%0d hs=%0d expected lat=0 r=0 reads=0 hs=0",
                 cases[c][0], cases[c][1], o.lat, o.r, o.nrd, o.hs[0] + o.hs[1] + o.hs[2]);
      else passed++;
    end
    a = rand_acts();
    ref_job(4, 7, 8'd100, a, er, ero, n);
    run_job(4, 7, 8'd100, a, 0, o);
    total++;
    if (o.nrd != 5 || o.hs[3] != 5 || !o.addr_ok) $display("FAIL clamp_count: got reads=%0d sums=%0d expected 5 5", o.nrd, o.hs[3]);
    else passed++;
    total++;
    if (o.r !== er || o.ro !== ero) $display("FAIL clamp_result: got %h/%b expected %h/%b", o.r, o.ro, er, ero);
    else passed++;
  endtask
  task automatic test_overflow();
    obs_t o;
    mem[40] = {16'd0, 16'd0, 16'd1, 16'd0, 16'd1};
    mem[41] = {16'd0, 16'd0, 16'h7fff, 16'h7fff, 16'h7fff};
    mem[42] = {16'd0, 16'd0, 16'd0, 16'd1, 16'd0};
    rdy_mode = 0;
    run_job(3, 3, 8'd40, {9'd0, 9'd0, 9'd100, 9'd100, 9'd100}, 0, o);
    total++;
    if (o.ro !== 5'b00010) $display("FAIL overflow_bits: got %b expected 00010", o.ro);
    else passed++;
    total++;
    if (o.r[9:0] !== 10'd200 || o.r[29:20] !== 10'd100 || o.r[49:30] !== '0)
      $display("FAIL overflow_sums: got %h expected lanes 200,x,100,0,0", o.r);
    else passed++;
`ifdef NEURON_LAYER_DRIVER_OVF_COUNT_EN
    total++;
    if (o.ovc !== 4'd1) $display("FAIL overflow_count: got %0d expected 1", o.ovc);
    else passed++;
`endif
  endtask
  task automatic test_wrap();
    obs_t o;
    logic [LM*NOW-1:0] er;
    logic [LM-1:0] ero;
    logic [NN*AW-1:0] a;
    int n;
    rdy_mode = 0;
    a = rand_acts();
    ref_job(5, 2, 8'd255, a, er, ero, n);
    run_job(5, 2, 8'd255, a, 0, o);
    total++;
    if (o.nrd != 2 || !o.addr_ok) $display("FAIL wrap_addr: got %0d reads addr_ok=%0d expected 2 reads at 255,0", o.nrd, o.addr_ok);
    else passed++;
    total++;
    if (o.r !== er || o.ro !== ero) $display("FAIL wrap_result: got %h/%b expected %h/%b", o.r, o.ro, er, ero);
    else passed++;
  endtask
  task automatic test_reset_mid();
    obs_t o;
    logic [LM*NOW-1:0] er;
    logic [LM-1:0] ero;
    logic [NN*AW-1:0] a;
    int n, k;
    rdy_mode = 3;
    @(negedge clk);
    start_valid = 1; in_count = 4'd2; out_count = 4'd3; activations = rand_acts(); weight_base = 8'd5;
    @(negedge clk);
    start_valid = 0;
    k = 0;
    while (!inputs_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!inputs_valid) $display("FAIL resetmid_issue: got inputs_valid=0 expected 1 within 20 cycles");
    else passed++;
    rst = 1;
    @(negedge clk);
    total++;
    if ({input_number_valid, inputs_valid, weights_valid, weight_rd, neuron_sum_ready, result_valid, start_ready} !== 7'b0000001 ||
        result !== '0)
      $display("FAIL resetmid_abort: got %b expected 0000001", {input_number_valid, inputs_valid, weights_valid, weight_rd,
               neuron_sum_ready, result_valid, start_ready});
    else passed++;
    rst = 0;
    rdy_mode = 0;
    a = rand_acts();
    ref_job(3, 4, 8'd60, a, er, ero, n);
    run_job(3, 4, 8'd60, a, 0, o);
    total++;
    if (o.r !== er || o.ro !== ero || o.perr != 0)
      $display("FAIL resetmid_followup: got %h/%b perr=%0d expected %h/%b perr=0", o.r, o.ro, o.perr, er, ero);
    else passed++;
  endtask
  task automatic test_random();
    obs_t o;
    logic [LM*NOW-1:0] er;
    logic [LM-1:0] ero;
    logic [NN*AW-1:0] a;
    logic [ADW-1:0] b;
    int n, ic, oc;
    for (int t = 0; t < 25; t++) begin
      rdy_mode = $urandom_range(0, 2);
      early = $urandom_range(0, 1) == 1;
      ic = $urandom_range(1, 5);
      oc = $urandom_range(1, 6);
      b = ADW'($urandom);
      a = rand_acts();
      ref_job(ic, oc, b, a, er, ero, n);
      run_job(ic, oc, b, a, $urandom_range(0, 2), o);
      total++;
      if (o.r !== er) $display("FAIL rand%0d_result: got %h expected %h", t, o.r, er);
      else passed++;
      total++;
      if (o.ro !== ero) $display("FAIL rand%0d_ovf: got %b expected %b", t, o.ro, ero);
      else passed++;
      total++;
      if (o.nrd != n || !o.addr_ok || o.hs[3] != n)
        $display("FAIL rand%0d_reads: got %0d reads %0d sums addr_ok=%0d expected %0d", t, o.nrd, o.hs[3], o.addr_ok, n);
      else passed++;
      total++;
      if (o.perr != 0 || !o.ret_ok) $display("FAIL rand%0d_protocol: got perr=%0d ret_ok=%0d expected 0 1", t, o.perr, o.ret_ok);
      else passed++;
`ifdef NEURON_LAYER_DRIVER_OVF_COUNT_EN
      total++;
      if (o.ovc !== OW'($countones(ero))) $display("FAIL rand%0d_ovc: got %0d expected %0d", t, o.ovc, $countones(ero));
      else passed++;
`endif
    end
    early = 0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < NN; k++)
        mem[i][k*WW+:WW] = (i % 4 == 0) ? WW'($urandom) : WW'($urandom_range(0, 15)) - 16'd8;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_degenerate();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog");
  end
endmodule
